// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache write-back buffer.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    WR_MEM = 2'd2
  } wb_state_e;

  // Line width in bits: 32-bit words, 2**line_addr_len of them.
  function automatic int unsigned line_w(input int unsigned line_addr_len);
    return 32'd32 << line_addr_len;
  endfunction

endpackage

// File: rtl/wb_line_fifo.sv
// Circular store of pending (address, line) evictions with head/tail/count.
// With WB_RD_FWD_EN defined, also provides a youngest-match address search port.
module wb_line_fifo
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_LEN = 10,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned DEPTH    = 4,
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [ADDR_LEN-1:0] push_addr_i,
  input  logic [LINE_W-1:0]   push_line_i,
  input  logic                pop_i,
  output logic [ADDR_LEN-1:0] head_addr_o,
  output logic [LINE_W-1:0]   head_line_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                empty_o,
  output logic                full_o
`ifdef WB_RD_FWD_EN
  ,
  input  logic [ADDR_LEN-1:0] srch_addr_i,
  output logic                srch_hit_o,
  output logic [LINE_W-1:0]   srch_line_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_LEN-1:0] addr_q [DEPTH];
  logic [LINE_W-1:0]   line_q [DEPTH];
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                empty_q, full_q;
  logic                do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_push) tail_q <= tail_q + PTR_W'(1);
      if (do_pop)  head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Payload storage; validity is tracked solely by head/count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[tail_q] <= push_addr_i;
      line_q[tail_q] <= push_line_i;
    end
  end

  assign head_addr_o = addr_q[head_q];
  assign head_line_o = line_q[head_q];
  assign count_o     = count_q;
  assign empty_o     = empty_q;
  assign full_o      = full_q;

`ifdef WB_RD_FWD_EN
  logic [PTR_W-1:0] srch_idx;

  // Walk oldest to youngest so the last valid match wins.
  always_comb begin
    srch_hit_o  = 1'b0;
    srch_line_o = '0;
    srch_idx    = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      srch_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[srch_idx] == srch_addr_i)) begin
        srch_hit_o  = 1'b1;
        srch_line_o = line_q[srch_idx];
      end
    end
  end
`endif

endmodule

// File: rtl/cache_wb_buffer.sv
// Write-back buffer between cache and main memory: absorbs evictions, drains FIFO-order when idle.
// Optional read-hit forwarding from pending entries is enabled by defining WB_RD_FWD_EN.
module cache_wb_buffer
  import cache_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 10,
  parameter int unsigned DEPTH         = 4,
  localparam int unsigned LINE_W       = line_w(LINE_ADDR_LEN),
  localparam int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                up_rd_req,
  input  logic                up_wr_req,
  input  logic [ADDR_LEN-1:0] up_addr,
  input  logic [LINE_W-1:0]   up_wr_line,
  output logic [LINE_W-1:0]   up_rd_line,
  output logic                up_gnt,
  output logic                mem_rd_req,
  output logic                mem_wr_req,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [LINE_W-1:0]   mem_wr_line,
  input  logic [LINE_W-1:0]   mem_rd_line,
  input  logic                mem_gnt,
  output logic [CNT_W-1:0]    wb_count,
  output logic                wb_empty,
  output logic                wb_full
);

  wb_state_e           state_q, state_d;
  logic                up_gnt_q, up_gnt_d;
  logic [LINE_W-1:0]   up_rd_line_q, up_rd_line_d;
  logic                mem_rd_req_q, mem_rd_req_d;
  logic                mem_wr_req_q, mem_wr_req_d;
  logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wr_line_q, mem_wr_line_d;

  logic                push_c, pop_c;
  logic [ADDR_LEN-1:0] head_addr_c;
  logic [LINE_W-1:0]   head_line_c;
`ifdef WB_RD_FWD_EN
  logic                fwd_hit_c;
  logic [LINE_W-1:0]   fwd_line_c;
`endif

  wb_line_fifo #(
    .ADDR_LEN (ADDR_LEN),
    .LINE_W   (LINE_W),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_c),
    .push_addr_i (up_addr),
    .push_line_i (up_wr_line),
    .pop_i       (pop_c),
    .head_addr_o (head_addr_c),
    .head_line_o (head_line_c),
    .count_o     (wb_count),
    .empty_o     (wb_empty),
    .full_o      (wb_full)
`ifdef WB_RD_FWD_EN
    ,
    .srch_addr_i (up_addr),
    .srch_hit_o  (fwd_hit_c),
    .srch_line_o (fwd_line_c)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      up_gnt_q      <= 1'b0;
      up_rd_line_q  <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_wr_req_q  <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_line_q <= '0;
    end else begin
      state_q       <= state_d;
      up_gnt_q      <= up_gnt_d;
      up_rd_line_q  <= up_rd_line_d;
      mem_rd_req_q  <= mem_rd_req_d;
      mem_wr_req_q  <= mem_wr_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_line_q <= mem_wr_line_d;
    end
  end

  // The gnt cycle is skipped entirely: the cache still holds its old request then.
  always_comb begin
    state_d       = state_q;
    up_gnt_d      = 1'b0;
    up_rd_line_d  = up_rd_line_q;
    mem_rd_req_d  = mem_rd_req_q;
    mem_wr_req_d  = mem_wr_req_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_line_d = mem_wr_line_q;
    push_c        = 1'b0;
    pop_c         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!up_gnt_q) begin
`ifdef WB_RD_FWD_EN
          if (up_rd_req && fwd_hit_c) begin
            up_rd_line_d = fwd_line_c;
            up_gnt_d     = 1'b1;
          end else if (up_rd_req) begin
`else
          if (up_rd_req && wb_empty) begin
`endif
            mem_rd_req_d = 1'b1;
            mem_addr_d   = up_addr;
            state_d      = RD_MEM;
          end else if (up_wr_req && !up_rd_req && !wb_full) begin
            push_c   = 1'b1;
            up_gnt_d = 1'b1;
          end else if (!wb_empty) begin
            mem_wr_req_d  = 1'b1;
            mem_addr_d    = head_addr_c;
            mem_wr_line_d = head_line_c;
            state_d       = WR_MEM;
          end
        end
      end
      RD_MEM: begin
        if (mem_gnt) begin
          up_rd_line_d = mem_rd_line;
          up_gnt_d     = 1'b1;
          mem_rd_req_d = 1'b0;
          state_d      = IDLE;
        end
      end
      WR_MEM: begin
        // Head entry stays valid (and forwardable) until memory accepts it.
        if (mem_gnt) begin
          pop_c        = 1'b1;
          mem_wr_req_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign up_gnt      = up_gnt_q;
  assign up_rd_line  = up_rd_line_q;
  assign mem_rd_req  = mem_rd_req_q;
  assign mem_wr_req  = mem_wr_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_line = mem_wr_line_q;

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Directed bench for cache_wb_buffer with a 10-cycle-latency memory model.
// Exercises the forwarding or non-forwarding path depending on WB_RD_FWD_EN.
module tb_cache_wb_buffer;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 3;

  logic          clk;
  logic          rst;
  logic          up_rd_req, up_wr_req;
  logic [AW-1:0] up_addr;
  logic [LW-1:0] up_wr_line, up_rd_line;
  logic          up_gnt;
  logic          mem_rd_req, mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wr_line, mem_rd_line;
  logic          mem_gnt;
  logic [CW-1:0] wb_count;
  logic          wb_empty, wb_full;

  cache_wb_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .up_rd_req   (up_rd_req),
    .up_wr_req   (up_wr_req),
    .up_addr     (up_addr),
    .up_wr_line  (up_wr_line),
    .up_rd_line  (up_rd_line),
    .up_gnt      (up_gnt),
    .mem_rd_req  (mem_rd_req),
    .mem_wr_req  (mem_wr_req),
    .mem_addr    (mem_addr),
    .mem_wr_line (mem_wr_line),
    .mem_rd_line (mem_rd_line),
    .mem_gnt     (mem_gnt),
    .wb_count    (wb_count),
    .wb_empty    (wb_empty),
    .wb_full     (wb_full)
  );

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    return {8{22'h2B5A5, a}};
  endfunction

  // Memory model: grant 10 cycles after a request is first seen; logs writes.
  logic [LW-1:0] mem_store [int];
  logic [AW-1:0] wr_log [$];
  logic [LW-1:0] wr_dat [$];
  int            wait_cnt = 0;
  logic          prev_gnt = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_gnt  = 1'b0;
      wait_cnt = 0;
      prev_gnt = 1'b0;
    end else begin
      if (mem_rd_req || mem_wr_req) chk("rd_wr_overlap", LW'(mem_rd_req & mem_wr_req), '0);
      if (up_gnt) chk("gnt_one_cycle", LW'(prev_gnt), '0);
      prev_gnt = up_gnt;
      if (mem_gnt) begin
        mem_gnt  = 1'b0;
        wait_cnt = 0;
      end else if (mem_rd_req || mem_wr_req) begin
        wait_cnt++;
        if (wait_cnt == 10) begin
          mem_gnt = 1'b1;
          if (mem_wr_req) begin
            mem_store[int'(mem_addr)] = mem_wr_line;
            wr_log.push_back(mem_addr);
            wr_dat.push_back(mem_wr_line);
          end else begin
            mem_rd_line = mem_store.exists(int'(mem_addr)) ? mem_store[int'(mem_addr)] : pat(mem_addr);
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [LW-1:0] l, output int cyc);
    up_wr_req  = 1'b1;
    up_addr    = a;
    up_wr_line = l;
    cyc        = 0;
    do begin
      tick();
      cyc++;
    end while (!up_gnt && cyc < 200);
    if (!up_gnt) chk("wr_timeout", '0, LW'(1));
    up_wr_req = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [LW-1:0] l, output int cyc,
                    output bit saw_rd, output logic [AW-1:0] rd_addr);
    up_rd_req = 1'b1;
    up_addr   = a;
    cyc       = 0;
    saw_rd    = 1'b0;
    rd_addr   = '0;
    do begin
      tick();
      cyc++;
      if (mem_rd_req && !saw_rd) begin
        saw_rd  = 1'b1;
        rd_addr = mem_addr;
      end
    end while (!up_gnt && cyc < 200);
    if (!up_gnt) chk("rd_timeout", '0, LW'(1));
    l         = up_rd_line;
    up_rd_req = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!(wb_empty && !mem_wr_req && !mem_rd_req) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk(tag, '0, LW'(1));
  endtask

  initial begin
    logic [LW-1:0] l1, l2, l3, got;
    logic [AW-1:0] ra;
    int            cyc, n, sz;
    bit            saw;

    l1 = {4{64'h0123_4567_89AB_CDEF}};
    l2 = {8{32'hA2A2_0002}};
    l3 = {8{32'hB3B3_0003}};
    rst = 1'b1;
    up_rd_req = 1'b0;
    up_wr_req = 1'b0;
    up_addr = '0;
    up_wr_line = '0;
    mem_rd_line = '0;
    mem_gnt = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_up_gnt", LW'(up_gnt), '0);
    chk("rst_mem_rd", LW'(mem_rd_req), '0);
    chk("rst_mem_wr", LW'(mem_wr_req), '0);
    chk("rst_count", LW'(wb_count), '0);
    chk("rst_empty", LW'(wb_empty), LW'(1));
    chk("rst_full", LW'(wb_full), '0);
    chk("rst_rd_line", up_rd_line, '0);
    rst = 1'b0;
    tick();

    // 1: single eviction, one-cycle grant, then drained
    wr(10'h011, l1, cyc);
    chk("t1_gnt_lat", LW'(cyc), LW'(1));
    chk("t1_count", LW'(wb_count), LW'(1));
    n = 0;
    while (!mem_wr_req && n < 20) begin tick(); n++; end
    chk("t1_mem_wr", LW'(mem_wr_req), LW'(1));
    chk("t1_mem_addr", LW'(mem_addr), LW'(10'h011));
    chk("t1_mem_data", mem_wr_line, l1);
    wait_empty("t1_drain_timeout");
    chk("t1_nwr", LW'(wr_log.size()), LW'(1));

    // 2: fill to full, fifth write stalls until first drain completes
    wr_log.delete();
    wr_dat.delete();
    wr(10'h001, {8{32'h5000_0001}}, cyc);
    chk("t2_lat_w1", LW'(cyc), LW'(1));
    for (int i = 2; i <= 4; i++) begin
      wr(AW'(i), {8{32'h5000_0000 + 32'(i)}}, cyc);
      chk("t2_lat_w", LW'(cyc), LW'(2));
    end
    chk("t2_full", LW'(wb_full), LW'(1));
    chk("t2_count", LW'(wb_count), LW'(4));
    wr(10'h005, {8{32'h5000_0005}}, cyc);
    chk("t2_lat_w5", LW'(cyc), LW'(13));
    chk("t2_wr_before_gnt", LW'(wr_log.size()), LW'(1));
    wait_empty("t2_drain_timeout");
    sz = wr_log.size();
    chk("t2_nwr", LW'(sz), LW'(5));
    for (int i = 0; i < 5; i++) begin
      chk("t2_order", (i < sz) ? LW'(wr_log[i]) : '1, LW'(i + 1));
    end
    chk("t2_data0", (sz > 0) ? wr_dat[0] : '1, {8{32'h5000_0001}});

`ifdef WB_RD_FWD_EN
    // 3: duplicate address, forwarding returns the younger line
    wr_log.delete();
    wr_dat.delete();
    wr(10'h020, l2, cyc);
    chk("t3_lat_w1", LW'(cyc), LW'(1));
    wr(10'h020, l3, cyc);
    chk("t3_lat_w2", LW'(cyc), LW'(2));
    rd(10'h020, got, cyc, saw, ra);
    chk("t3_rd_lat", LW'(cyc), LW'(2));
    chk("t3_rd_data", got, l3);
    chk("t3_no_mem_rd", LW'(saw), '0);
    wait_empty("t3_drain_timeout");
    sz = wr_log.size();
    chk("t3_nwr", LW'(sz), LW'(2));
    chk("t3_drain_old", (sz > 0) ? wr_dat[0] : '1, l2);
    chk("t3_drain_new", (sz > 1) ? wr_dat[1] : '1, l3);
`else
    // 5: no forwarding, read waits for drain then fetches drained data
    wr_log.delete();
    wr_dat.delete();
    wr(10'h020, l2, cyc);
    chk("t5_lat_w", LW'(cyc), LW'(1));
    rd(10'h020, got, cyc, saw, ra);
    chk("t5_rd_lat", LW'(cyc), LW'(23));
    chk("t5_saw_mem_rd", LW'(saw), LW'(1));
    chk("t5_rd_addr", LW'(ra), LW'(10'h020));
    chk("t5_rd_data", got, l2);
    chk("t5_nwr", LW'(wr_log.size()), LW'(1));
`endif

    // 4: read miss with empty buffer goes to memory
    wait_empty("t4_pre_timeout");
    tick();
    rd(10'h3FF, got, cyc, saw, ra);
    chk("t4_saw_mem_rd", LW'(saw), LW'(1));
    chk("t4_rd_addr", LW'(ra), LW'(10'h3FF));
    chk("t4_rd_lat", LW'(cyc), LW'(11));
    chk("t4_rd_data", got, pat(10'h3FF));
    tick();

    // 6: reset in the middle of a drain discards everything
    wr(10'h100, l1, cyc);
    wr(10'h101, l2, cyc);
    wr(10'h102, l3, cyc);
    n = 0;
    while (!mem_wr_req && n < 20) begin tick(); n++; end
    chk("t6_draining", LW'(mem_wr_req), LW'(1));
    chk("t6_count3", LW'(wb_count), LW'(3));
    chk("t6_head_addr", LW'(mem_addr), LW'(10'h100));
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t6_mem_wr", LW'(mem_wr_req), '0);
    chk("t6_mem_rd", LW'(mem_rd_req), '0);
    chk("t6_up_gnt", LW'(up_gnt), '0);
    chk("t6_count", LW'(wb_count), '0);
    chk("t6_empty", LW'(wb_empty), LW'(1));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_drain", LW'(mem_wr_req), '0);
    chk("t6_count_after", LW'(wb_count), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
